unidad_control_mc: RTL



---
 rtl/uc_pkg.sv | 32 +++
 rtl/unidad_control_mc_if.sv | 28 ++
 rtl/uc_decoder.sv | 34 +++
 rtl/unidad_control_mc.sv | 123 ++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared constants and enums for the multi-cycle control unit.
// Opcodes and ALU codes are the 3-bit/4-bit base encodings; wider buses zero-extend.
package uc_pkg;

  localparam logic [2:0] OPC_ADD = 3'b000;
  localparam logic [2:0] OPC_SUB = 3'b001;
  localparam logic [2:0] OPC_SLT = 3'b010;
  localparam logic [2:0] OPC_SW  = 3'b011;
  localparam logic [2:0] OPC_LW  = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_STORE,
    CLS_LOAD,
    CLS_ILLEGAL
  } cls_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM_WR,
    ST_MEM_RD,
    ST_WB,
    ST_ERR
  } state_e;

endpackage

// File: rtl/unidad_control_mc_if.sv
// Instruction handshake plus datapath control lines of the control unit.
// master = instruction fetch side, slave = control unit.
interface unidad_control_mc_if #(
  parameter int OPC_W    = 3,
  parameter int ALU_OP_W = 4
);
  logic                inst_valid;
  logic [OPC_W-1:0]    inst;
  logic                inst_ready;
  logic                busy;
  logic                done;
  logic                err;
  logic                wEnable_BR;
  logic                SEL_dmx;
  logic [ALU_OP_W-1:0] OP_alu;
  logic                W_ram;
  logic                R_ram;

  modport master (
    output inst_valid, inst,
    input  inst_ready, busy, done, err, wEnable_BR, SEL_dmx, OP_alu, W_ram, R_ram
  );

  modport slave (
    input  inst_valid, inst,
    output inst_ready, busy, done, err, wEnable_BR, SEL_dmx, OP_alu, W_ram, R_ram
  );
endinterface

// File: rtl/uc_decoder.sv
// Combinational opcode decoder: opcode -> {class, 4-bit ALU code, legal}.
module uc_decoder
  import uc_pkg::*;
#(
  parameter int OPC_W = 3
) (
  input  logic [OPC_W-1:0] i_opc,
  output cls_e             o_cls,
  output logic [3:0]       o_alu,
  output logic             o_legal
);

  logic w_upper;

  // Any bit above bit 2 makes the opcode illegal regardless of the low bits.
  assign w_upper = (i_opc >> 3) != '0;

  always_comb begin
    o_cls = CLS_ILLEGAL;
    o_alu = '0;
    if (!w_upper) begin
      case (i_opc[2:0])
        OPC_ADD: begin o_cls = CLS_R;     o_alu = ALU_ADD;  end
        OPC_SUB: begin o_cls = CLS_R;     o_alu = ALU_SUB;  end
        OPC_SLT: begin o_cls = CLS_R;     o_alu = ALU_SLT;  end
        OPC_SW:  begin o_cls = CLS_STORE; o_alu = ALU_PASS; end
        OPC_LW:  begin o_cls = CLS_LOAD;  o_alu = ALU_SLT;  end
        default: ;
      endcase
    end
    o_legal = (o_cls != CLS_ILLEGAL);
  end

endmodule

// File: rtl/unidad_control_mc.sv
// Multi-cycle control unit: accepts one opcode per valid/ready handshake and
// sequences it through EXEC, memory and write-back phases (Moore outputs).
module unidad_control_mc
  import uc_pkg::*;
#(
  parameter int OPC_W    = 3,
  parameter int ALU_OP_W = 4,
  parameter int RAM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  unidad_control_mc_if.slave bus
);

  localparam int              CNT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RAM_LAT - 1);

  state_e           r_state, w_next;
  logic [OPC_W-1:0] r_opc;
  logic [OPC_W-1:0] w_dec_opc;
  logic [CNT_W-1:0] r_cnt;
  cls_e             w_cls;
  logic [3:0]       w_alu;
  logic             w_legal;
  logic             w_accept;

  logic                w_ready, w_busy, w_done, w_err;
  logic                w_wen, w_sel, w_wram, w_rram;
  logic [ALU_OP_W-1:0] w_op;

  assign w_accept  = bus.inst_valid && (r_state == ST_IDLE);
  // In IDLE the live opcode is decoded for the legal check; afterwards the captured one.
  assign w_dec_opc = (r_state == ST_IDLE) ? bus.inst : r_opc;

  uc_decoder #(.OPC_W(OPC_W)) u_dec (
    .i_opc   (w_dec_opc),
    .o_cls   (w_cls),
    .o_alu   (w_alu),
    .o_legal (w_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_opc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_opc <= bus.inst;
      if (r_state == ST_EXEC && w_cls == CLS_LOAD) r_cnt <= CNT_INIT;
      else if (r_state == ST_MEM_RD && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_wen   = 1'b0;
    w_sel   = 1'b0;
    w_wram  = 1'b0;
    w_rram  = 1'b0;
    w_op    = '0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
        if (w_accept) w_next = w_legal ? ST_EXEC : ST_ERR;
      end
      ST_EXEC: begin
        w_op  = ALU_OP_W'(w_alu);
        w_sel = (w_cls == CLS_STORE) || (w_cls == CLS_LOAD);
        case (w_cls)
          CLS_STORE: w_next = ST_MEM_WR;
          CLS_LOAD:  w_next = ST_MEM_RD;
          default:   w_next = ST_WB;
        endcase
      end
      ST_MEM_WR: begin
        w_wram = 1'b1;
        w_sel  = 1'b1;
        w_op   = ALU_OP_W'(ALU_PASS);
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      ST_MEM_RD: begin
        w_rram = 1'b1;
        w_sel  = 1'b1;
        w_op   = ALU_OP_W'(ALU_SLT);
        if (r_cnt == '0) w_next = ST_WB;
      end
      ST_WB: begin
        w_wen  = 1'b1;
        w_done = 1'b1;
        w_op   = ALU_OP_W'(w_alu);
        w_sel  = (w_cls == CLS_LOAD);
        w_next = ST_IDLE;
      end
      ST_ERR: begin
        w_done = 1'b1;
        w_err  = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  assign bus.inst_ready = w_ready;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.err        = w_err;
  assign bus.wEnable_BR = w_wen;
  assign bus.SEL_dmx    = w_sel;
  assign bus.OP_alu     = w_op;
  assign bus.W_ram      = w_wram;
  assign bus.R_ram      = w_rram;

endmodule
